// File: rtl/spi_frame_decoder.sv
// Purpose: assemble SPI bytes into a fixed-length frame, validate it, publish the last good frame.
// Latency: frame_out/frame_valid_out/error_out update one cycle after cs_active_in is first sampled low.
// Backpressure: none; every counted byte is consumed. Optional checksum byte: SPI_FRAME_CHECKSUM_EN.
module spi_frame_decoder #(
  parameter int FRAME_BITS     = 89,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid_in,
  input  logic                  cs_active_in,
  output logic [FRAME_BITS-1:0] frame_out,
  output logic                  frame_valid_out,
  output logic                  error_out,
  output logic [7:0]            error_count_out,
  output logic                  stale_out
);

  localparam int FRAME_BYTES = (FRAME_BITS + 7) / 8;
`ifdef SPI_FRAME_CHECKSUM_EN
  localparam int EXP_BYTES = FRAME_BYTES + 1;
`else
  localparam int EXP_BYTES = FRAME_BYTES;
`endif
  localparam int CNT_W   = $clog2(EXP_BYTES + 1);
  localparam int STALE_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0]   EXP_CNT   = CNT_W'(EXP_BYTES);
  localparam logic [CNT_W-1:0]   FRAME_CNT = CNT_W'(FRAME_BYTES);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_OVFL = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] asm_q, asm_d;
  logic                  prev_cs_q;
  logic [STALE_W-1:0]    stale_cnt_q;
  logic                  cs_rise, cs_fall, take, accept, reject, sum_ok;
`ifdef SPI_FRAME_CHECKSUM_EN
  logic [7:0]            xor_q, xor_d;
`endif

  // Frame tracking: edge detect on cs, byte counting/shifting, and the accept/reject verdict.
  always_comb begin
    cs_rise = cs_active_in & ~prev_cs_q;
    cs_fall = ~cs_active_in & prev_cs_q;
    // A byte on the start cycle belongs to the new frame; bytes outside a frame are dropped.
    take    = byte_valid_in & cs_active_in & (cs_rise | (state_q != ST_IDLE));
    state_d = cs_rise ? ST_RECV : state_q;
    cnt_d   = cs_rise ? '0 : cnt_q;
    asm_d   = asm_q;
`ifdef SPI_FRAME_CHECKSUM_EN
    xor_d   = cs_rise ? 8'h00 : xor_q;
`endif
    if (take && (state_d != ST_OVFL)) begin
      if (cnt_d == EXP_CNT) begin
        state_d = ST_OVFL;
      end else begin
        // Only payload bytes enter the assembly register; padding falls off the top.
        if (cnt_d < FRAME_CNT) begin
          asm_d = {asm_q[FRAME_BITS-9:0], byte_in};
        end
`ifdef SPI_FRAME_CHECKSUM_EN
        // Running XOR over payload and checksum byte is zero exactly when the checksum matches.
        xor_d = xor_d ^ byte_in;
`endif
        cnt_d = cnt_d + CNT_W'(1);
      end
    end
    if (cs_fall) begin
      state_d = ST_IDLE;
    end
`ifdef SPI_FRAME_CHECKSUM_EN
    sum_ok = (xor_q == 8'h00);
`else
    sum_ok = 1'b1;
`endif
    accept = cs_fall & (state_q == ST_RECV) & (cnt_q == EXP_CNT) & sum_ok;
    // A cs drop with no frame open (e.g. cs high across reset) produces nothing.
    reject = cs_fall & (state_q != ST_IDLE) & ~accept;
  end

  // Registered frame state, outputs, error counter and stale timer.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      asm_q           <= '0;
      prev_cs_q       <= 1'b1;
      frame_out       <= '0;
      frame_valid_out <= 1'b0;
      error_out       <= 1'b0;
      error_count_out <= 8'h00;
      stale_cnt_q     <= STALE_MAX;
`ifdef SPI_FRAME_CHECKSUM_EN
      xor_q           <= 8'h00;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      asm_q           <= asm_d;
      prev_cs_q       <= cs_active_in;
      frame_valid_out <= accept;
      error_out       <= reject;
`ifdef SPI_FRAME_CHECKSUM_EN
      xor_q           <= xor_d;
`endif
      if (accept) begin
        frame_out <= asm_q;
      end
      if (reject && (error_count_out != 8'hFF)) begin
        error_count_out <= error_count_out + 8'd1;
      end
      if (accept) begin
        stale_cnt_q <= '0;
      end else if (stale_cnt_q != STALE_MAX) begin
        stale_cnt_q <= stale_cnt_q + STALE_W'(1);
      end
    end
  end

  assign stale_out = (stale_cnt_q == STALE_MAX);

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Scoreboard bench for spi_frame_decoder: stimulus pushes expected publish/reject events,
// a negedge monitor pops and compares them whenever frame_valid_out or error_out fires.
// Build with +define+SPI_FRAME_CHECKSUM_EN to exercise the checksum variant.
module tb_spi_frame_decoder;

  localparam int FB = 89;
  localparam int TO = 100;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [7:0]    byte_in;
  logic          byte_valid_in;
  logic          cs_active_in;
  logic [FB-1:0] frame_out;
  logic          frame_valid_out;
  logic          error_out;
  logic [7:0]    error_count_out;
  logic          stale_out;

  spi_frame_decoder #(.FRAME_BITS(FB), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .byte_in         (byte_in),
    .byte_valid_in   (byte_valid_in),
    .cs_active_in    (cs_active_in),
    .frame_out       (frame_out),
    .frame_valid_out (frame_valid_out),
    .error_out       (error_out),
    .error_count_out (error_count_out),
    .stale_out       (stale_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit            is_err;
    logic [FB-1:0] frame;
    logic [7:0]    cnt;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [7:0]    bq[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            last_valid_cyc = 0;
  logic [FB-1:0] model_frame;
  logic [7:0]    model_err;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the oldest pending expectation.
  always @(negedge clk_in) begin
    if (!rst_in && (frame_valid_out || error_out)) begin
      check("pulse_exclusive", {95'd0, frame_valid_out & error_out}, 96'd0);
      check("pending_expect", {95'd0, exp_q.size() > 0}, 96'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind_err", {95'd0, error_out}, {95'd0, e.is_err});
        check("frame_out", {7'd0, frame_out}, {7'd0, e.frame});
        check("error_count", {88'd0, error_count_out}, {88'd0, e.cnt});
        check("pulse_cycle", 96'(cyc), 96'(e.cyc));
        if (frame_valid_out) last_valid_cyc = cyc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset(input logic cs_level);
    rst_in = 1'b1; cs_active_in = cs_level; byte_valid_in = 1'b0; byte_in = 8'h00;
    repeat (3) tick();
    rst_in = 1'b0;
    model_frame = '0;
    model_err   = 8'h00;
  endtask

  // Twelve payload bytes MSB-first, plus the XOR byte in the checksum build.
  task automatic load_good(input logic [95:0] d);
    logic [7:0] x;
    x = 8'h00;
    bq.delete();
    for (int i = 0; i < 12; i++) begin
      bq.push_back(d[95-8*i -: 8]);
      x = x ^ d[95-8*i -: 8];
    end
`ifdef SPI_FRAME_CHECKSUM_EN
    bq.push_back(x);
`endif
  endtask

  // mode: 0 accept, 1 reject, 2 ignored (no pulse expected).
  task automatic run_frame(input int mode, input logic [FB-1:0] exp_frame, input bit byte_on_start);
    exp_t e;
    int   k;
    k = 0;
    cs_active_in = 1'b1;
    if (byte_on_start && bq.size() > 0) begin
      byte_in = bq[0]; byte_valid_in = 1'b1; k = 1;
    end
    tick();
    for (int i = k; i < bq.size(); i++) begin
      byte_in = bq[i]; byte_valid_in = 1'b1;
      tick();
    end
    byte_valid_in = 1'b0;
    if (mode == 0) model_frame = exp_frame;
    if (mode == 1 && model_err != 8'hFF) model_err = model_err + 8'd1;
    e.is_err = (mode == 1);
    e.frame  = model_frame;
    e.cnt    = model_err;
    e.cyc    = cyc + 1;
    if (mode != 2) exp_q.push_back(e);
    cs_active_in = 1'b0;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk_in);
    check("drain_pending", 96'(exp_q.size()), 96'd0);
  endtask

  logic [95:0] fa, fb_d, fc, fd, fe;
  int          stale_cyc;

  initial begin
    fa   = 96'h00_01_02_03_04_05_06_07_08_09_0A_0B;
    fb_d = 96'hFF_11_22_33_44_55_66_77_88_99_AA_BB;
    fc   = 96'h01_DE_AD_BE_EF_01_23_45_67_89_AB_CD;
    fd   = 96'h00_F0_F1_F2_F3_F4_F5_F6_F7_F8_F9_FA;
    fe   = 96'h00_10_20_30_40_50_60_70_80_90_A0_B0;

    do_reset(1'b0);
    @(negedge clk_in);
    check("rst_frame_out", {7'd0, frame_out}, 96'd0);
    check("rst_frame_valid", {95'd0, frame_valid_out}, 96'd0);
    check("rst_error", {95'd0, error_out}, 96'd0);
    check("rst_error_count", {88'd0, error_count_out}, 96'd0);
    check("rst_stale", {95'd0, stale_out}, 96'd1);
    tick();

    // Good frame, first byte arriving on the cs rise cycle.
    load_good(fa);
    run_frame(0, 89'h0102030405060708090A0B, 1'b1);
    check("stale_after_good", {95'd0, stale_out}, 96'd0);
    tick();

    // One byte short, then one byte long.
    load_good(fa); void'(bq.pop_back());
    run_frame(1, '0, 1'b0);
    tick();
    load_good(fa); bq.push_back(8'h5A);
    run_frame(1, '0, 1'b0);
    drain();
    check("frame_held_after_errors", {7'd0, frame_out}, {7'd0, 89'h0102030405060708090A0B});

    // Bytes while cs is low are ignored; padding bits of the first byte are dropped.
    byte_valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      byte_in = 8'hEE;
      tick();
    end
    byte_valid_in = 1'b0;
    load_good(fb_d);
    run_frame(0, 89'h1_1122334455_66778899AABB, 1'b0);

    // Zero-byte frame is rejected.
    bq.delete();
    run_frame(1, '0, 1'b0);
    drain();

    // Saturation of the error counter.
    bq.delete();
    for (int i = 0; i < 300; i++) run_frame(1, '0, 1'b0);
    drain();
    check("err_count_saturated", {88'd0, error_count_out}, 96'd255);

    // Back-to-back frames with a single cs-low cycle between them.
    load_good(fd);
    run_frame(0, 89'hF0F1F2F3F4F5F6F7F8F9FA, 1'b0);
    load_good(fe);
    run_frame(0, 89'h102030405060708090A0B0, 1'b1);
    drain();

    // cs held high across reset release: that frame must be dropped silently.
    repeat (2) tick();
    do_reset(1'b1);
    load_good(fc);
    run_frame(2, '0, 1'b0);
    repeat (4) tick();
    check("ignored_frame_out", {7'd0, frame_out}, 96'd0);
    check("ignored_err_count", {88'd0, error_count_out}, 96'd0);
    load_good(fc);
    run_frame(0, 89'h1_DEADBEEF_0123456789ABCD, 1'b0);
    drain();

    // Stale timer: rises exactly TO cycles after the publish cycle.
    stale_cyc = -1000;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_in);
      if (stale_out) begin
        stale_cyc = cyc;
        break;
      end
    end
    check("stale_delay", 96'(stale_cyc - last_valid_cyc), 96'(TO));
    tick();
    load_good(fa);
    run_frame(0, 89'h0102030405060708090A0B, 1'b0);
    check("stale_cleared", {95'd0, stale_out}, 96'd0);
    drain();

`ifdef SPI_FRAME_CHECKSUM_EN
    // Checksum off by one bit: rejected, held frame unchanged.
    load_good(fc);
    bq[12] = bq[12] ^ 8'h01;
    run_frame(1, '0, 1'b0);
    drain();
    check("cksum_frame_held", {7'd0, frame_out}, {7'd0, 89'h0102030405060708090A0B});
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
